seq_multiplier: RTL and testbench

Parametrised unsigned shift-add multiplier with a start/done handshake; the sequential successor to the fixed-width combinational multipliers in the FPGA coursework.
Trades area for latency by processing one multiplier bit per clock.
Sits between a register or bus front-end that issues operands and a consumer that samples the product on done.

---
 rtl/seq_multiplier.sv | 96 +++++++++
 tb/tb_seq_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock, start/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to leave CALC once no set multiplier bits remain.
module seq_multiplier #(
    parameter int M_WIDTH = 4,
    parameter int Q_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [M_WIDTH-1:0]         m,
    input  logic [Q_WIDTH-1:0]         q,
    output logic                       busy,
    output logic                       done,
    output logic [M_WIDTH+Q_WIDTH-1:0] p
);

    localparam int P_WIDTH = M_WIDTH + Q_WIDTH;
    localparam int CNT_W   = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(Q_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t               r_state;
    logic [P_WIDTH-1:0]   r_mcand;
    logic [P_WIDTH-1:0]   r_acc;
    logic [Q_WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [P_WIDTH-1:0]   r_p;

    logic [P_WIDTH-1:0]   w_acc_next;
    logic [Q_WIDTH-1:0]   w_mplier_shr;
    logic                 w_last;

    always_comb begin
        w_acc_next   = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end
        w_mplier_shr = r_mplier >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Remaining multiplier bits all zero: further iterations add nothing.
        w_last       = (w_mplier_shr == '0);
`else
        w_last       = (r_cnt == LAST_ITER);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= P_WIDTH'(m);
                        r_mplier <= q;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_p     <= w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at default widths (4x4 -> 8-bit product).
// Honours SEQ_MULT_EARLY_TERM_EN for expected latencies.
module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] m;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.M_WIDTH(4), .Q_WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] qv);
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (qv[3])      return 4;
        else if (qv[2]) return 3;
        else if (qv[1]) return 2;
        else            return 1;
`else
        return (qv === 4'bx) ? 0 : 4;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done rises (bounded), checking busy stays high meanwhile.
    task automatic wait_done(input string tag, output int lat);
        bit busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "_timeout"}, 32'(lat < 20), 32'd1);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    endtask

    task automatic run_op(input logic [3:0] mi, input logic [3:0] qi, input logic [7:0] exp_p,
                          input int exp_lat, input string tag);
        int lat;
        m     = mi;
        q     = qi;
        start = 1'b1;
        step();
        start = 1'b0;
        m     = ~mi;
        q     = ~qi;
        wait_done(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_p"}, 32'(p), 32'(exp_p));
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int dcount;
        rst   = 1'b1;
        start = 1'b0;
        m     = '0;
        q     = '0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_p", 32'(p), 32'd0);
        end
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_p", 32'(p), 32'd0);

        // Single op 15*15
        run_op(4'd15, 4'd15, 8'd225, lat_of(4'd15), "single");
        step();
        check("single_done_fall", 32'(done), 32'd0);
        check("single_p_hold", 32'(p), 32'd225);

        // Hand-picked vectors including zero operands and extremes
        run_op(4'd0,  4'd9,  8'd0,   lat_of(4'd9),  "m0");
        run_op(4'd13, 4'd0,  8'd0,   lat_of(4'd0),  "q0");
        run_op(4'd5,  4'd1,  8'd5,   lat_of(4'd1),  "q1");
        run_op(4'd6,  4'd7,  8'd42,  lat_of(4'd7),  "v6x7");
        run_op(4'd11, 4'd8,  8'd88,  lat_of(4'd8),  "v11x8");

        // Exhaustive sweep; each op starts in the previous op's done cycle
        for (int mi = 0; mi < 16; mi++) begin
            for (int qi = 0; qi < 16; qi++) begin
                run_op(4'(mi), 4'(qi), 8'(mi * qi), lat_of(4'(qi)), "exh");
            end
        end
        step();

        // Start while busy is ignored
        m = 4'd3; q = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        m = 4'd9; q = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign", lat);
        check("ign_p", 32'(p), 32'd15);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) dcount++;
        end
        check("ign_extra_done", 32'(dcount), 32'd0);
        check("ign_busy", 32'(busy), 32'd0);

        // Back-to-back with start held high
        m = 4'd2; q = 4'd3; start = 1'b1;
        step();
        m = 4'd7; q = 4'd6;
        wait_done("b2b1", lat);
        check("b2b1_lat", 32'(lat), 32'(lat_of(4'd3)));
        check("b2b1_p", 32'(p), 32'd6);
        step();
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy), 32'd1);
        wait_done("b2b2", lat);
        check("b2b_gap", 32'(lat + 1), 32'(lat_of(4'd6) + 1));
        check("b2b2_p", 32'(p), 32'd42);
        step();

        // Reset mid-operation
        m = 4'd12; q = 4'd11; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", 32'(p), 32'd0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) dcount++;
        end
        check("abort_quiet", 32'(dcount), 32'd0);

        // rst and start together: rst wins
        m = 4'd4; q = 4'd4; start = 1'b1; rst = 1'b1;
        step();
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        step();
        check("rst_start_idle", 32'(busy | done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
